// File: rtl/fcs_ctrl.sv
// fcs_ctrl: frame sequencer that shares one CRC-16 FCS engine between the TX and RX paths.
// Build option: define FCS_CTRL_RXCHK_EN to include the receive check path.
module fcs_ctrl (
    input  logic        econet_clk,
    input  logic        reset,
    input  logic        abort,
    input  logic        tx_start,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic        tx_done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        rx_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_end,
    output logic        rx_done,
    output logic        rx_good,
    output logic        rx_overrun,
    output logic        fcs_clr,
    output logic        fcs_en,
    output logic [7:0]  fcs_data,
    input  logic [15:0] fcs_val,
    output logic        busy
);

    // state     | meaning
    // IDLE      | no frame; arbitrate rx_start / tx_start / tx_pend
    // CLR       | fcs_clr high for one cycle
    // TX_DATA   | pass payload bytes to output and engine
    // TX_SYNC   | engine absorbs the last payload byte
    // TX_FCS_LO | load ~fcs_val[7:0] when the output slot frees
    // TX_FCS_HI | load ~fcs_val[15:8], pulse tx_done
    // RX_DATA   | feed received bytes until rx_end
    // RX_SYNC   | engine absorbs the last received byte
    // RX_CHECK  | compare residue, pulse rx_done
`ifdef FCS_CTRL_RXCHK_EN
    typedef enum logic [3:0] {
        IDLE, CLR, TX_DATA, TX_SYNC, TX_FCS_LO, TX_FCS_HI, RX_DATA, RX_SYNC, RX_CHECK
    } state_t;
    localparam logic [15:0] FCSGOOD = 16'hF0B8;
    logic rx_req;
    logic mode_rx, mode_rx_nxt;
    assign rx_req = rx_start;
`else
    typedef enum logic [3:0] {
        IDLE, CLR, TX_DATA, TX_SYNC, TX_FCS_LO, TX_FCS_HI
    } state_t;
    logic rx_req;
    logic unused_rx;
    assign rx_req    = 1'b0;
    assign unused_rx = ^{rx_start, rx_data, rx_valid, rx_end};
`endif

    state_t      state, state_nxt;
    logic        tx_pend, tx_pend_nxt;
    logic        slot_free;
    logic [7:0]  out_data_nxt, fcs_data_nxt;
    logic        out_valid_nxt, fcs_en_nxt, fcs_clr_nxt;
    logic        tx_done_nxt, rx_done_nxt, rx_good_nxt, rx_overrun_nxt;

    assign slot_free = !out_valid || out_ready;
    assign tx_ready  = (state == TX_DATA) && slot_free;
    assign busy      = (state != IDLE);

    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (rx_req || tx_start || tx_pend) state_nxt = CLR;
                CLR: begin
`ifdef FCS_CTRL_RXCHK_EN
                    state_nxt = mode_rx ? RX_DATA : TX_DATA;
`else
                    state_nxt = TX_DATA;
`endif
                end
                TX_DATA:   if (tx_valid && tx_ready && tx_last) state_nxt = TX_SYNC;
                TX_SYNC:   state_nxt = TX_FCS_LO;
                TX_FCS_LO: if (slot_free) state_nxt = TX_FCS_HI;
                TX_FCS_HI: if (slot_free) state_nxt = IDLE;
`ifdef FCS_CTRL_RXCHK_EN
                RX_DATA:   if (rx_end) state_nxt = RX_SYNC;
                RX_SYNC:   state_nxt = RX_CHECK;
                RX_CHECK:  state_nxt = IDLE;
`endif
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        out_data_nxt   = out_data;
        out_valid_nxt  = out_valid && !out_ready;
        fcs_en_nxt     = 1'b0;
        fcs_data_nxt   = fcs_data;
        fcs_clr_nxt    = (state_nxt == CLR);
        tx_done_nxt    = 1'b0;
        rx_done_nxt    = 1'b0;
        rx_good_nxt    = rx_good;
        rx_overrun_nxt = 1'b0;
        tx_pend_nxt    = tx_pend;
`ifdef FCS_CTRL_RXCHK_EN
        mode_rx_nxt    = mode_rx;
`endif
        if (state != IDLE) begin
            if (tx_start) tx_pend_nxt = 1'b1;
            if (rx_req)   rx_overrun_nxt = 1'b1;
        end
        if (abort && state != IDLE) begin
            out_valid_nxt = 1'b0;
            tx_pend_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_req) begin
`ifdef FCS_CTRL_RXCHK_EN
                        mode_rx_nxt = 1'b1;
`endif
                        // a TX request losing arbitration is remembered
                        if (tx_start) tx_pend_nxt = 1'b1;
                    end else if (tx_start || tx_pend) begin
`ifdef FCS_CTRL_RXCHK_EN
                        mode_rx_nxt = 1'b0;
`endif
                        tx_pend_nxt = 1'b0;
                    end
                end
                TX_DATA: begin
                    if (tx_valid && tx_ready) begin
                        out_data_nxt  = tx_data;
                        out_valid_nxt = 1'b1;
                        fcs_en_nxt    = 1'b1;
                        fcs_data_nxt  = tx_data;
                    end
                end
                TX_FCS_LO: begin
                    if (slot_free) begin
                        out_data_nxt  = ~fcs_val[7:0];
                        out_valid_nxt = 1'b1;
                    end
                end
                TX_FCS_HI: begin
                    if (slot_free) begin
                        out_data_nxt  = ~fcs_val[15:8];
                        out_valid_nxt = 1'b1;
                        tx_done_nxt   = 1'b1;
                    end
                end
`ifdef FCS_CTRL_RXCHK_EN
                RX_DATA: begin
                    if (rx_valid) begin
                        fcs_en_nxt   = 1'b1;
                        fcs_data_nxt = rx_data;
                    end
                end
                RX_CHECK: begin
                    rx_good_nxt = (fcs_val == FCSGOOD);
                    rx_done_nxt = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge econet_clk or posedge reset) begin
        if (reset) begin
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            fcs_en     <= 1'b0;
            fcs_data   <= 8'h00;
            fcs_clr    <= 1'b0;
            tx_done    <= 1'b0;
            rx_done    <= 1'b0;
            rx_good    <= 1'b0;
            rx_overrun <= 1'b0;
            tx_pend    <= 1'b0;
`ifdef FCS_CTRL_RXCHK_EN
            mode_rx    <= 1'b0;
`endif
        end else begin
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            fcs_en     <= fcs_en_nxt;
            fcs_data   <= fcs_data_nxt;
            fcs_clr    <= fcs_clr_nxt;
            tx_done    <= tx_done_nxt;
            rx_done    <= rx_done_nxt;
            rx_good    <= rx_good_nxt;
            rx_overrun <= rx_overrun_nxt;
            tx_pend    <= tx_pend_nxt;
`ifdef FCS_CTRL_RXCHK_EN
            mode_rx    <= mode_rx_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fcs_ctrl.sv
// tb_fcs_ctrl: self-checking bench for fcs_ctrl with a behavioural CRC-16 engine attached.
// Expectations follow FCS_CTRL_RXCHK_EN the same way the design does.
module tb_fcs_ctrl;

`ifdef FCS_CTRL_RXCHK_EN
    localparam bit RXCHK = 1'b1;
`else
    localparam bit RXCHK = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    typedef struct {
        bit         is_rx;
        int         rdy_mode;
        int         flip_idx;
        logic [7:0] fcs_lo;
        logic [7:0] fcs_hi;
        bit         exp_good;
    } vec_t;

    logic        econet_clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic        tx_start = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_last = 1'b0;
    logic        tx_ready, tx_done;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        rx_start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_end = 1'b0;
    logic        rx_done, rx_good, rx_overrun;
    logic        fcs_clr, fcs_en;
    logic [7:0]  fcs_data;
    logic [15:0] fcs_val;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int rdy_mode = 0;

    fcs_ctrl dut (
        .econet_clk(econet_clk), .reset(reset), .abort(abort),
        .tx_start(tx_start), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .tx_done(tx_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .rx_start(rx_start), .rx_data(rx_data), .rx_valid(rx_valid), .rx_end(rx_end),
        .rx_done(rx_done), .rx_good(rx_good), .rx_overrun(rx_overrun),
        .fcs_clr(fcs_clr), .fcs_en(fcs_en), .fcs_data(fcs_data), .fcs_val(fcs_val),
        .busy(busy)
    );

    always #5 econet_clk = ~econet_clk;

    function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c = c_in;
        for (int i = 0; i < 8; i++)
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

    function automatic logic [15:0] crc_q(input bq_t q);
        logic [15:0] c = 16'hFFFF;
        foreach (q[i]) c = crc_byte(c, q[i]);
        return c;
    endfunction

    // a frame is good when its last two bytes are the complemented CRC of the rest, low first
    function automatic bit model_good(input bq_t b);
        bq_t p;
        logic [15:0] c;
        if (b.size() < 2) return 1'b0;
        for (int i = 0; i < b.size() - 2; i++) p.push_back(b[i]);
        c = ~crc_q(p);
        return (b[b.size()-2] == c[7:0]) && (b[b.size()-1] == c[15:8]);
    endfunction

    task automatic make_frame(input bq_t p, output bq_t r);
        logic [15:0] c;
        c = ~crc_q(p);
        r = p;
        r.push_back(c[7:0]);
        r.push_back(c[15:8]);
    endtask

    // shared FCS engine; fcs_clr is ORed onto its reset
    logic [15:0] eng_crc;
    logic        eng_rst;
    assign eng_rst = reset | fcs_clr;
    always @(posedge econet_clk or posedge eng_rst) begin
        if (eng_rst)     eng_crc <= 16'hFFFF;
        else if (fcs_en) eng_crc <= crc_byte(eng_crc, fcs_data);
    end
    assign fcs_val = eng_crc;

    always @(posedge econet_clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = !out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    logic [7:0] got[$];
    int         n_tx_done = 0, n_rx_done = 0, n_ovr = 0, n_clr = 0, hold_bad = 0;
    logic [7:0] done_byte = 8'h00, prev_data = 8'h00;
    bit         prev_stall = 1'b0;

    always @(negedge econet_clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(out_valid && out_data == prev_data)) hold_bad++;
            prev_stall = out_valid && !out_ready && !abort;
            prev_data  = out_data;
            if (out_valid && out_ready) got.push_back(out_data);
            if (tx_done) begin n_tx_done++; done_byte = out_data; end
            if (rx_done) n_rx_done++;
            if (rx_overrun) n_ovr++;
            if (fcs_clr) n_clr++;
        end
    end

    int s_base, s_txd, s_rxd, s_ovr, s_clr, s_hold;

    task automatic snap();
        s_base = got.size(); s_txd = n_tx_done; s_rxd = n_rx_done;
        s_ovr = n_ovr; s_clr = n_clr; s_hold = hold_bad;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge econet_clk);
        #1;
    endtask

    task automatic chk_outs(input string name);
        chk(name, 32'({tx_ready, tx_done, out_data, out_valid, rx_done, rx_good, rx_overrun,
                       fcs_clr, fcs_en, fcs_data, busy}), 32'd0);
    endtask

    task automatic start_tx();
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
    endtask

    task automatic send_tx(input bq_t b);
        int t;
        for (int i = 0; i < b.size(); i++) begin
            tx_data  = b[i];
            tx_valid = 1'b1;
            tx_last  = (i == b.size() - 1);
            t = 0;
            @(negedge econet_clk);
            while (!tx_ready && t < 200) begin
                @(negedge econet_clk);
                t++;
            end
            chk("tx_accept_timeout", 32'(t < 200), 32'd1);
            tick();
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic check_tx_tail(input bq_t payload, input int exp_clr, input int exp_ovr);
        bq_t exp;
        int  t;
        make_frame(payload, exp);
        t = 0;
        while ((got.size() < s_base + exp.size() || busy || out_valid) && t < 400) begin
            tick();
            t++;
        end
        chk("tx_drain_timeout", 32'(t < 400), 32'd1);
        chk("tx_len", 32'(got.size() - s_base), 32'(exp.size()));
        for (int i = 0; i < exp.size() && s_base + i < got.size(); i++)
            chk("tx_byte", 32'(got[s_base+i]), 32'(exp[i]));
        chk("tx_done_cnt", 32'(n_tx_done - s_txd), 32'd1);
        chk("tx_done_byte", 32'(done_byte), 32'(exp[exp.size()-1]));
        chk("fcs_clr_cnt", 32'(n_clr - s_clr), 32'(exp_clr));
        chk("rx_overrun_cnt", 32'(n_ovr - s_ovr), 32'(exp_ovr));
        chk("out_hold", 32'(hold_bad - s_hold), 32'd0);
    endtask

    task automatic run_tx(input bq_t payload, input int mode);
        rdy_mode = mode;
        snap();
        start_tx();
        send_tx(payload);
        check_tx_tail(payload, 1, 0);
    endtask

    task automatic rx_body(input bq_t b, input bit gaps, input bit end_sep, input bit good);
        tick();
        for (int i = 0; i < b.size(); i++) begin
            if (gaps && $urandom_range(0, 2) == 0) tick();
            rx_data  = b[i];
            rx_valid = 1'b1;
            rx_end   = (i == b.size() - 1) && !end_sep;
            tick();
            rx_valid = 1'b0;
            rx_end   = 1'b0;
        end
        if (end_sep || b.size() == 0) begin
            rx_end = 1'b1;
            tick();
            rx_end = 1'b0;
        end
        tick();
        tick();
        chk("rx_done", 32'(rx_done), 32'(RXCHK));
        chk("rx_good", 32'(rx_good), 32'(RXCHK & good));
        tick();
        chk("rx_done_pulse", 32'(rx_done), 32'd0);
        chk("rx_good_hold", 32'(rx_good), 32'(RXCHK & good));
    endtask

    task automatic run_rx(input bq_t b, input bit gaps, input bit end_sep);
        snap();
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        rx_body(b, gaps, end_sep, model_good(b));
        chk("rx_clr_cnt", 32'(n_clr - s_clr), 32'(RXCHK));
        chk("rx_done_cnt", 32'(n_rx_done - s_rxd), 32'(RXCHK));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        bq_t  p, fr, q;
        int   n;

        vecs[0] = '{is_rx: 1'b0, rdy_mode: 0, flip_idx: -1, fcs_lo: 8'h6E, fcs_hi: 8'h90, exp_good: 1'b0};
        vecs[1] = '{is_rx: 1'b0, rdy_mode: 1, flip_idx: -1, fcs_lo: 8'h6E, fcs_hi: 8'h90, exp_good: 1'b0};
        vecs[2] = '{is_rx: 1'b1, rdy_mode: 0, flip_idx: -1, fcs_lo: 8'h6E, fcs_hi: 8'h90, exp_good: 1'b1};
        vecs[3] = '{is_rx: 1'b1, rdy_mode: 0, flip_idx:  2, fcs_lo: 8'h6E, fcs_hi: 8'h90, exp_good: 1'b0};
        vecs[4] = '{is_rx: 1'b0, rdy_mode: 2, flip_idx: -1, fcs_lo: 8'h6E, fcs_hi: 8'h90, exp_good: 1'b0};
        vecs[5] = '{is_rx: 1'b1, rdy_mode: 0, flip_idx: 10, fcs_lo: 8'h6E, fcs_hi: 8'h90, exp_good: 1'b0};
        for (int i = 0; i < 9; i++) p.push_back(8'h31 + 8'(i));

        repeat (3) @(posedge econet_clk);
        #1;
        chk_outs("reset_outputs");
        reset = 1'b0;
        tick();
        chk_outs("idle_after_reset");

        foreach (vecs[v]) begin
            if (vecs[v].is_rx) begin
                fr = p;
                fr.push_back(vecs[v].fcs_lo);
                fr.push_back(vecs[v].fcs_hi);
                if (vecs[v].flip_idx >= 0) fr[vecs[v].flip_idx] ^= 8'h01;
                run_rx(fr, 1'b0, 1'b0);
                chk("vec_rx_good", 32'(rx_good), 32'(RXCHK & vecs[v].exp_good));
            end else begin
                run_tx(p, vecs[v].rdy_mode);
                if (got.size() >= s_base + 11) begin
                    chk("vec_fcs_lo", 32'(got[s_base+9]), 32'(vecs[v].fcs_lo));
                    chk("vec_fcs_hi", 32'(got[s_base+10]), 32'(vecs[v].fcs_hi));
                end
            end
        end

        // simultaneous requests: RX first, then TX from the pending flag
        make_frame(p, fr);
        rdy_mode = 0;
        snap();
        tx_start = 1'b1;
        rx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        rx_start = 1'b0;
        rx_body(fr, 1'b0, 1'b0, 1'b1);
        send_tx(p);
        check_tx_tail(p, RXCHK ? 2 : 1, 0);

        // abort while stalled in the FCS-low state
        rdy_mode = 0;
        snap();
        start_tx();
        send_tx(p);
        rdy_mode = 3;
        tick();
        tick();
        chk("abort_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("abort_no_done", 32'(n_tx_done - s_txd), 32'd0);
        chk("abort_stays_idle", 32'(busy), 32'd0);
        chk("abort_bytes_out", 32'(got.size() - s_base), 32'd8);
        run_tx(p, 0);

        // rx_start during a TX frame
        rdy_mode = 0;
        snap();
        fork
            begin
                start_tx();
                send_tx(p);
            end
            begin
                repeat (5) @(posedge econet_clk);
                #1;
                rx_start = 1'b1;
                tick();
                rx_start = 1'b0;
            end
        join
        check_tx_tail(p, 1, RXCHK ? 1 : 0);

        // asynchronous reset in the middle of a frame
        rdy_mode = 3;
        start_tx();
        tick();
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_out_valid", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("reset_mid_frame");
        tick();
        reset = 1'b0;
        tick();
        run_tx(p, 0);

        for (int k = 0; k < 24; k++) begin
            q.delete();
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 12);
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                run_tx(q, $urandom_range(0, 2));
            end else begin
                n = $urandom_range(0, 10);
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                make_frame(q, fr);
                if ($urandom_range(0, 2) == 0)
                    fr[$urandom_range(0, fr.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
                run_rx(fr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fcs_ctrl.md
# fcs_ctrl

Frame-level sequencer for the single shared Econet FCS (CRC-16, reflected, init 16'hFFFF) engine. It arbitrates the engine between the transmit and receive paths on a per-frame basis and clears it at the start of each frame. On transmit it feeds payload bytes through and appends the complemented FCS, low byte first. On receive it feeds every byte, including the two received FCS bytes, and checks the residue against the good-frame constant.

## Interface
- FCSGOOD, 16'hF0B8, receive residue that indicates a good frame.
- econet_clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- abort  in  1  drop the current frame and return to IDLE.
- tx_start  in  1  pulse: request a transmit frame.
- tx_data / tx_valid / tx_last  in  8/1/1  payload byte stream; tx_last marks the final payload byte.
- tx_ready  out  1  payload byte accepted when tx_valid && tx_ready.
- tx_done  out  1  one-cycle pulse when the second FCS byte is loaded to the output.
- out_data / out_valid  out  8/1  byte stream to the serialiser (payload then FCS).
- out_ready  in  1  serialiser consumes out_data when out_valid && out_ready.
- rx_start  in  1  pulse: receive frame begins.
- rx_data / rx_valid  in  8/1  received bytes, FCS bytes included; no backpressure.
- rx_end  in  1  pulse: frame ended. If asserted together with rx_valid, that byte is processed first.
- rx_done / rx_good  out  1/1  rx_done pulses one cycle; rx_good is valid with rx_done and held until the next rx_done.
- rx_overrun  out  1  one-cycle pulse when rx_start arrives while busy.
- fcs_clr  out  1  registered clear. The top level ORs it with reset onto the engine's reset input.
- fcs_en / fcs_data  out  1/8  registered engine enable and byte.
- fcs_val  in  16  engine output.
- busy  out  1  high in any state other than IDLE.

## Operation
- Reset: state IDLE. All outputs are 0: tx_ready, tx_done, out_data, out_valid, rx_done, rx_good, rx_overrun, fcs_clr, fcs_en, fcs_data, busy. The tx_pend flag is 0.
- IDLE transitions:
  - rx_start goes to CLR with mode RX. rx_start has priority over tx_start when both arrive together.
  - Otherwise tx_start or tx_pend goes to CLR with mode TX, and tx_pend clears.
- tx_start while busy sets tx_pend. rx_start while busy pulses rx_overrun and is otherwise ignored.
- CLR: fcs_clr=1 for exactly one cycle, then go to TX_DATA or RX_DATA.
- TX_DATA:
  - tx_ready = !out_valid || out_ready (combinational).
  - On accept: out_data<=tx_data, out_valid<=1, fcs_en<=1, fcs_data<=tx_data.
  - If tx_last is set on the accepted byte, go to TX_SYNC.
- TX_SYNC: one cycle, waiting for the engine to absorb the last byte. Then go to TX_FCS_LO.
- TX_FCS_LO: when the output slot is free, out_data<=~fcs_val[7:0] and go to TX_FCS_HI. fcs_en stays 0.
- TX_FCS_HI: when the output slot is free, out_data<=~fcs_val[15:8], pulse tx_done, go to IDLE.
- out_valid clears on any out_ready handshake that does not coincide with a new load.
- RX_DATA:
  - Each rx_valid gives fcs_en<=1, fcs_data<=rx_data.
  - rx_end goes to RX_SYNC.
- RX_SYNC: one cycle, then RX_CHECK.
- RX_CHECK: rx_good<=(fcs_val==FCSGOOD), rx_done<=1, go to IDLE.
- rx_start during RX_DATA is an overrun: pulse rx_overrun, and the frame in progress continues.
- abort, from any state: go to IDLE; clear out_valid, fcs_en and tx_pend; no done pulse. abort in IDLE has no effect.
- rx_valid outside RX_DATA is ignored.

## Timing
- fcs_en is asserted the cycle after a byte is accepted. fcs_val reflects that byte one cycle later.
- TX: the last payload byte is accepted at edge E0. The earliest FCS-low load is at edge E2, and the earliest FCS-high load is one cycle after the FCS-low byte is consumed.
- TX throughput is one byte per cycle while out_ready=1.
- RX: with rx_end at edge E0, rx_done is high in the cycle following edge E2.
- Frame start: start pulse at edge S0, fcs_clr high after S0, first byte accepted at S2 or later. tx_ready is 0 in CLR.
- Back-to-back frames: at least 2 idle cycles (IDLE then CLR) between a done pulse and the next data accept.
- Reset mid-frame: state and outputs return to their reset values immediately. The engine is cleared via the global reset.

## Configuration
- FCS_CTRL_RXCHK_EN defined: the receive path is present as described.
- FCS_CTRL_RXCHK_EN undefined:
  - rx_* inputs are ignored and rx_start never wins arbitration.
  - rx_done, rx_good and rx_overrun are tied to 0.
  - States RX_DATA, RX_SYNC and RX_CHECK are absent.
  - Ports are unchanged.

## Test plan
- TX with payload "123456789" (0x31..0x39), out_ready=1: out stream is 0x31..0x39, 0x6E, 0x90. tx_done pulses once with the 0x90 load.
- RX with the 11 bytes above, then rx_end: fcs_val=16'hF0B8 at RX_CHECK, rx_done=1, rx_good=1. Flip one bit of byte 3: rx_good=0.
- Arbitration: rx_start and tx_start asserted in the same IDLE cycle. The RX frame runs first, then the TX frame starts from tx_pend with no second request, and fcs_clr pulses before each frame.
- Backpressure: out_ready toggled 1/0 every cycle during the TX case above. The stream is unchanged, with no duplicated or lost bytes, and out_data is stable while out_valid && !out_ready.
- abort during TX_FCS_LO: out_valid=0 next cycle, no tx_done, busy=0. A following tx_start produces the correct 0x6E/0x90 FCS.
- rx_start during an active TX frame: rx_overrun pulses for 1 cycle and the TX frame completes unchanged. With FCS_CTRL_RXCHK_EN undefined, rx_done and rx_good stay 0 for the whole RX case.
